// File: rtl/cp0_pkg.sv
// cp0_pkg: constants shared by the CP0 block and its users.
// Holds the CP0 register numbers, the SR/Cause bit-field positions, the
// ExcCode encodings and the default reset values for PRId and the handler
// entry PC. The optional Count register (CP0_COUNT_EN) uses CP0_REG_COUNT.
package cp0_pkg;

  // CP0 register numbers
  localparam logic [4:0] CP0_REG_COUNT = 5'd9;
  localparam logic [4:0] CP0_REG_SR    = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE = 5'd13;
  localparam logic [4:0] CP0_REG_EPC   = 5'd14;
  localparam logic [4:0] CP0_REG_PRID  = 5'd15;

  // SR field positions
  localparam int SR_IM_LO  = 10;
  localparam int SR_IM_HI  = 15;
  localparam int SR_EXL    = 1;
  localparam int SR_IE     = 0;

  // Cause field positions
  localparam int CAUSE_BD    = 31;
  localparam int CAUSE_IP_LO = 10;
  localparam int CAUSE_IP_HI = 15;
  localparam int CAUSE_EC_LO = 2;
  localparam int CAUSE_EC_HI = 6;

  // ExcCode values
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] PRID_DEFAULT         = 32'h2021_0707;
  localparam logic [31:0] HANDLER_ADDR_DEFAULT = 32'h0000_4180;

endpackage

// File: rtl/cp0_unit_arbiter.sv
// cp0_arbiter: purely combinational interrupt/exception arbitration.
// Ports:
//   sr_im     - SR.IM interrupt mask
//   sr_exl    - SR.EXL, blocks everything while a handler runs
//   sr_ie     - SR.IE global interrupt enable
//   hw_int    - hardware interrupt vector
//   exc_code  - M-stage exception code, 0 = none
//   int_hit   - an enabled interrupt is pending
//   exc_hit   - an exception is being raised
//   req       - take interrupt/exception this cycle
module cp0_arbiter (
  input  logic [5:0] sr_im,
  input  logic       sr_exl,
  input  logic       sr_ie,
  input  logic [5:0] hw_int,
  input  logic [4:0] exc_code,
  output logic       int_hit,
  output logic       exc_hit,
  output logic       req
);

  always_comb begin
    int_hit = sr_ie & ~sr_exl & (|(hw_int & sr_im));
    exc_hit = ~sr_exl & (exc_code != 5'd0);
    req     = int_hit | exc_hit;
  end

endmodule

// File: rtl/cp0_unit.sv
// cp0_unit: system coprocessor 0 (SR, Cause, EPC, PRId, optional Count).
// Arbitrates interrupts against M-stage exceptions, raises the redirect
// request and serves mfc0/mtc0/eret.
// Ports:
//   clk, reset         - clock, async active-high reset
//   rd_addr / rdata    - combinational mfc0 read (pre-edge state, no bypass)
//   wr_addr/wdata/we   - mtc0 write, suppressed when req is high
//   pc, bd, exc_code   - M-stage instruction info
//   eret               - clears EXL when no req is taken
//   hw_int             - hardware interrupt vector, sampled into Cause.IP
//   epc_out            - current EPC for the eret redirect
//   handler_pc         - constant exception entry address
//   req                - take interrupt/exception (flush + redirect)
// Build option: define CP0_COUNT_EN to add the free-running Count register (9).
module cp0_unit
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID_VAL     = PRID_DEFAULT,
  parameter logic [31:0] HANDLER_ADDR = HANDLER_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rd_addr,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic [31:0] pc,
  input  logic        bd,
  input  logic [4:0]  exc_code,
  input  logic        eret,
  input  logic [5:0]  hw_int,
  output logic [31:0] rdata,
  output logic [31:0] epc_out,
  output logic [31:0] handler_pc,
  output logic        req
);

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] epc_q, epc_d;

  logic        int_hit;
  logic        exc_hit;
  logic        wr_en;
  logic [31:0] pc_al;

  cp0_arbiter u_arbiter (
    .sr_im    (im_q),
    .sr_exl   (exl_q),
    .sr_ie    (ie_q),
    .hw_int   (hw_int),
    .exc_code (exc_code),
    .int_hit  (int_hit),
    .exc_hit  (exc_hit),
    .req      (req)
  );

  // The instruction being trapped must not commit its mtc0.
  assign wr_en = we & ~req;
  assign pc_al = pc & ~32'd3;

  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ip_d       = hw_int;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;

    if (req) begin
      exl_d      = 1'b1;
      exc_code_d = int_hit ? EXC_INT : exc_code;
      bd_d       = bd;
      // Delay-slot faults restart at the branch; wraps modulo 2^32.
      epc_d      = bd ? (pc_al - 32'd4) : pc_al;
    end else begin
      if (eret) begin
        exl_d = 1'b0;
      end
      if (wr_en) begin
        case (wr_addr)
          CP0_REG_SR: begin
            im_d  = wdata[SR_IM_HI:SR_IM_LO];
            exl_d = wdata[SR_EXL];
            ie_d  = wdata[SR_IE];
          end
          CP0_REG_EPC: epc_d = wdata & ~32'd3;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_q       <= '0;
      exc_code_q <= '0;
      epc_q      <= '0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_q       <= ip_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

`ifdef CP0_COUNT_EN
  logic [31:0] count_q, count_d;

  always_comb begin
    count_d = count_q + 32'd1;
    if (wr_en && (wr_addr == CP0_REG_COUNT)) begin
      count_d = wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end
`endif

  always_comb begin
    rdata = '0;
    case (rd_addr)
`ifdef CP0_COUNT_EN
      CP0_REG_COUNT: rdata = count_q;
`endif
      CP0_REG_SR:    rdata = {16'b0, im_q, 8'b0, exl_q, ie_q};
      CP0_REG_CAUSE: rdata = {bd_q, 15'b0, ip_q, 3'b0, exc_code_q, 2'b0};
      CP0_REG_EPC:   rdata = epc_q;
      CP0_REG_PRID:  rdata = PRID_VAL;
      default:       rdata = '0;
    endcase
  end

  assign epc_out    = epc_q;
  assign handler_pc = HANDLER_ADDR;

endmodule

// File: tb/tb_cp0_unit.sv
module tb_cp0_unit;
  import cp0_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rd_addr, wr_addr, exc_code;
  logic [31:0] wdata, pc;
  logic        we, bd, eret;
  logic [5:0]  hw_int;
  logic [31:0] rdata, epc_out, handler_pc;
  logic        req;

  int n_tests = 0;
  int n_fail  = 0;

  cp0_unit dut (
    .clk        (clk),
    .reset      (reset),
    .rd_addr    (rd_addr),
    .wr_addr    (wr_addr),
    .wdata      (wdata),
    .we         (we),
    .pc         (pc),
    .bd         (bd),
    .exc_code   (exc_code),
    .eret       (eret),
    .hw_int     (hw_int),
    .rdata      (rdata),
    .epc_out    (epc_out),
    .handler_pc (handler_pc),
    .req        (req)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs are changed 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    we = 1'b0; wr_addr = '0; wdata = '0; eret = 1'b0;
    exc_code = '0; bd = 1'b0; pc = '0;
  endtask

  task automatic rd_chk(input logic [4:0] a, input logic [31:0] exp, input string name);
    rd_addr = a;
    #1;
    n_tests++;
    if (rdata !== exp) begin
      n_fail++;
      $display("FAIL %s: rdata=%h expected=%h", name, rdata, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; idle_inputs(); hw_int = '0; rd_addr = '0;
    #12;
    rd_chk(CP0_REG_SR,    32'h0, "reset_sr");
    rd_chk(CP0_REG_CAUSE, 32'h0, "reset_cause");
    rd_chk(CP0_REG_EPC,   32'h0, "reset_epc");
    rd_chk(CP0_REG_PRID,  32'h2021_0707, "reset_prid");
    rd_chk(CP0_REG_COUNT, 32'h0, "reset_count");
    rd_chk(5'd3,          32'h0, "unmapped_read");
    n_tests++;
    if (req !== 1'b0) begin n_fail++; $display("FAIL reset_req: req=%b expected=0", req); end
    n_tests++;
    if (handler_pc !== 32'h0000_4180) begin
      n_fail++; $display("FAIL handler_pc: got=%h expected=00004180", handler_pc);
    end
    @(negedge clk);
    reset = 1'b0;
    step();
  endtask

  task automatic test_interrupt();
    we = 1'b1; wr_addr = CP0_REG_SR; wdata = 32'h0000_0401;
    step();
    idle_inputs();
    rd_chk(CP0_REG_SR, 32'h0000_0401, "sr_write");
    hw_int = 6'b000001; pc = 32'h3010; bd = 1'b0;
    #1;
    n_tests++;
    if (req !== 1'b1) begin n_fail++; $display("FAIL int_req: req=%b expected=1", req); end
    step();
    idle_inputs();
    #1;
    n_tests++;
    if (req !== 1'b0) begin n_fail++; $display("FAIL int_exl_block: req=%b expected=0", req); end
    rd_chk(CP0_REG_EPC,   32'h3010,      "int_epc");
    rd_chk(CP0_REG_CAUSE, 32'h0000_0400, "int_cause");
    rd_chk(CP0_REG_SR,    32'h0000_0403, "int_sr_exl");
    n_tests++;
    if (epc_out !== 32'h3010) begin n_fail++; $display("FAIL int_epc_out: got=%h expected=00003010", epc_out); end
    // Exception is also blocked while EXL is set.
    exc_code = EXC_ADES;
    #1;
    n_tests++;
    if (req !== 1'b0) begin n_fail++; $display("FAIL exc_exl_block: req=%b expected=0", req); end
    exc_code = '0;
  endtask

  task automatic test_exception();
    hw_int = '0;
    we = 1'b1; wr_addr = CP0_REG_SR; wdata = 32'h0;
    step();
    idle_inputs();
    rd_chk(CP0_REG_SR, 32'h0, "sr_clear");
    exc_code = EXC_OV; pc = 32'h3024; bd = 1'b1;
    #1;
    n_tests++;
    if (req !== 1'b1) begin n_fail++; $display("FAIL exc_req: req=%b expected=1", req); end
    step();
    idle_inputs();
    rd_chk(CP0_REG_EPC,   32'h3020,      "exc_epc_bd");
    rd_chk(CP0_REG_CAUSE, 32'h8000_0030, "exc_cause");
    rd_chk(CP0_REG_SR,    32'h0000_0002, "exc_sr_exl");
  endtask

  task automatic test_priority();
    we = 1'b1; wr_addr = CP0_REG_SR; wdata = 32'h0000_0801;
    step();
    idle_inputs();
    hw_int = 6'b000010; exc_code = EXC_ADEL; pc = 32'h5000; bd = 1'b0;
    we = 1'b1; wr_addr = CP0_REG_EPC; wdata = 32'h1234;
    #1;
    n_tests++;
    if (req !== 1'b1) begin n_fail++; $display("FAIL prio_req: req=%b expected=1", req); end
    step();
    idle_inputs();
    hw_int = '0;
    rd_chk(CP0_REG_EPC,   32'h5000,      "prio_epc_wr_suppressed");
    rd_chk(CP0_REG_CAUSE, 32'h0000_0800, "prio_cause_int_wins");
    rd_chk(CP0_REG_SR,    32'h0000_0803, "prio_sr");
  endtask

  task automatic test_eret();
    hw_int = 6'b000010; eret = 1'b1;
    #1;
    n_tests++;
    if (req !== 1'b0) begin n_fail++; $display("FAIL eret_req_blocked: req=%b expected=0", req); end
    n_tests++;
    if (epc_out !== 32'h5000) begin n_fail++; $display("FAIL eret_epc_out: got=%h expected=00005000", epc_out); end
    step();
    eret = 1'b0;
    rd_chk(CP0_REG_SR, 32'h0000_0801, "eret_exl_clear");
    n_tests++;
    if (req !== 1'b1) begin n_fail++; $display("FAIL eret_pending_req: req=%b expected=1", req); end
    pc = 32'h6007;
    step();
    idle_inputs();
    hw_int = '0;
    rd_chk(CP0_REG_EPC, 32'h6004, "epc_align");
  endtask

  task automatic test_epc_wrap();
    we = 1'b1; wr_addr = CP0_REG_SR; wdata = 32'h0;
    step();
    idle_inputs();
    exc_code = EXC_RI; pc = 32'h0; bd = 1'b1;
    step();
    idle_inputs();
    rd_chk(CP0_REG_EPC,   32'hFFFF_FFFC, "epc_wrap");
    rd_chk(CP0_REG_CAUSE, 32'h8000_0028, "wrap_cause");
    we = 1'b1; wr_addr = CP0_REG_CAUSE; wdata = 32'hFFFF_FFFF;
    step();
    we = 1'b1; wr_addr = CP0_REG_EPC; wdata = 32'h0000_1237;
    step();
    idle_inputs();
    rd_chk(CP0_REG_CAUSE, 32'h8000_0028, "cause_read_only");
    rd_chk(CP0_REG_EPC,   32'h0000_1234, "mtc0_epc_mask");
  endtask

  task automatic test_reset_mid_handler();
    // EXL is set from the wrap exception; enable interrupts too.
    we = 1'b1; wr_addr = CP0_REG_SR; wdata = 32'h0000_FC03;
    step();
    idle_inputs();
    hw_int = 6'h3F;
    #2;
    reset = 1'b1;
    #1;
    rd_chk(CP0_REG_SR,  32'h0, "midreset_sr");
    rd_chk(CP0_REG_EPC, 32'h0, "midreset_epc");
    n_tests++;
    if (req !== 1'b0) begin n_fail++; $display("FAIL midreset_req: req=%b expected=0", req); end
    @(negedge clk);
    reset = 1'b0;
    hw_int = '0;
    step();
  endtask

  task automatic test_count();
    we = 1'b1; wr_addr = CP0_REG_COUNT; wdata = 32'hFFFF_FFFE;
    step();
    idle_inputs();
`ifdef CP0_COUNT_EN
    rd_chk(CP0_REG_COUNT, 32'hFFFF_FFFE, "count_load");
    step();
    rd_chk(CP0_REG_COUNT, 32'hFFFF_FFFF, "count_inc");
    step();
    rd_chk(CP0_REG_COUNT, 32'h0, "count_wrap");
`else
    rd_chk(CP0_REG_COUNT, 32'h0, "count_absent_0");
    step();
    rd_chk(CP0_REG_COUNT, 32'h0, "count_absent_1");
    step();
    rd_chk(CP0_REG_COUNT, 32'h0, "count_absent_2");
`endif
  endtask

  initial begin
    test_reset();
    test_interrupt();
    test_exception();
    test_priority();
    test_eret();
    test_epc_wrap();
    test_reset_mid_handler();
    test_count();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cp0_unit.md
Name: cp0_unit

Overview:
- System coprocessor 0 sitting directly downstream of the mips top-level interrupt vector.
- Consumes the 6-bit hardware interrupt vector built from the external interrupt and the two timer IRQs, plus exception codes from the M stage.
- Holds SR, Cause, EPC and PRId, arbitrates interrupt vs. exception, and raises the redirect request to the pipeline.
- Serves mfc0/mtc0/eret for the CPU.

Parameters:
- PRID_VAL, 32'h2021_0707, read-only PRId contents.
- HANDLER_ADDR, 32'h0000_4180, exception entry PC driven on handler_pc.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- rd_addr  input  5  CP0 register number for mfc0 read
- wr_addr  input  5  CP0 register number for mtc0 write
- wdata  input  32  mtc0 write data
- we  input  1  mtc0 write enable (M stage)
- pc  input  32  PC of the M-stage instruction
- bd  input  1  M-stage instruction is in a branch delay slot
- exc_code  input  5  M-stage exception code, 0 = none
- eret  input  1  eret in M stage
- hw_int  input  6  {3'b0, interrupt, T0 irq, T1 irq}
- rdata  output  32  combinational read of rd_addr
- epc_out  output  32  current EPC, for eret redirect
- handler_pc  output  32  constant HANDLER_ADDR
- req  output  1  take interrupt/exception this cycle (flush + redirect)

Behaviour:
- Register map:
  - SR (12): IM[15:10], EXL[1], IE[0]; other bits read 0.
  - Cause (13): BD[31], IP[15:10], ExcCode[6:2]; other bits read 0.
  - EPC (14): 32 bits, bits[1:0] always 0.
  - PRId (15): PRID_VAL.
  - Any other address reads 0.
- Reset: IM=0, EXL=0, IE=0, BD=0, IP=0, ExcCode=0, EPC=0. req=0, since IE=0 and exc_code is expected 0.
- Arbitration, all combinational:
  - int_hit = IE & ~EXL & |(hw_int & IM)
  - exc_hit = ~EXL & (exc_code != 0)
  - req = int_hit | exc_hit
- Interrupt has priority over exception in the same cycle.
- IP update: Cause.IP <= hw_int every cycle, regardless of EXL. It is sampled, not latched.
- On req, at the clock edge:
  - EXL <= 1.
  - ExcCode <= int_hit ? 0 : exc_code.
  - BD <= bd.
  - EPC <= bd ? {pc[31:2],2'b0} - 4 : {pc[31:2],2'b0}.
- While req=1, the mtc0 write in the same cycle is suppressed; the faulting/interrupted instruction must not commit.
- eret, when req=0: EXL <= 0 at the edge. epc_out already presents EPC combinationally for the redirect.
- eret with req=1 cannot occur, because EXL=1 during the handler blocks req. If it does occur, req wins.
- mtc0, when req=0 and we=1:
  - 12 writes IM/EXL/IE.
  - 13 is read-only (ignored).
  - 14 writes EPC with bits[1:0] forced to 0.
  - 15 is ignored.
- Read/write collision:
  - rdata reflects pre-edge state; no internal bypass.
  - The pipeline forwards M to E for mfc0 after mtc0.
- EPC wrap: pc=0 with bd=1 gives 32'hFFFF_FFFC. Modulo-2^32 arithmetic, no special case.
- Reset mid-handler: all state clears asynchronously and req drops in the same cycle.

Optional Feature:
- CP0_COUNT_EN.
- When defined: register 9 (Count) is a 32-bit free-running up-counter.
  - Increments every clock and wraps 32'hFFFF_FFFF to 0.
  - mtc0 to 9 loads wdata; the loaded value takes priority over the increment that cycle.
  - Reset sets it to 0.
  - Readable via rdata.
- When undefined: address 9 reads 0, writes are ignored, and no counter flops are instantiated.

Decomposition:
- Shared constants header (alongside the existing address constants):
  - CP0 register numbers 9, 12, 13, 14, 15.
  - SR/Cause bit-field positions.
  - ExcCode values: Int=0, AdEL=4, AdES=5, RI=10, Ov=12.
  - HANDLER_ADDR default.
- Sub-module: cp0_arbiter, purely combinational, producing int_hit, exc_hit and req from SR, hw_int and exc_code. Register file and update logic stay in cp0_unit.

Test Plan:
- Reset, then read 12/13/14/15 → 0, 0, 0, 32'h2021_0707; req=0.
- mtc0 SR=32'h0000_0401 (IM[10]=1, IE=1); hw_int=6'b000001 with pc=32'h3010, bd=0 → req=1 same cycle. Next cycle: EPC=32'h3010, ExcCode=0, EXL=1, req=0 while hw_int stays asserted.
- EXL=0, IE=0; exc_code=12 with pc=32'h3024, bd=1 → req=1; EPC=32'h3020, BD=1, Cause[6:2]=12.
- Same cycle: hw_int[1] enabled and exc_code=4 → ExcCode=0 (interrupt wins); same-cycle we=1 to EPC is suppressed.
- In handler, eret → EXL clears next edge; epc_out=EPC; pending enabled hw_int raises req the following cycle.
- With CP0_COUNT_EN: mtc0 9=32'hFFFF_FFFE → reads FFFF_FFFE, FFFF_FFFF, 0 on successive cycles. Without the macro, reads 0.
